hidden_layer_sequencer: RTL and testbench

Initiator side of the `node` start/ready handshake: steps one shared `node` instance through all neurons of a layer. For each neuron it selects that neuron's weight row and bias, asserts `start`, waits for `ready`, and writes `out` into a result buffer. It keeps a running argmax so that, in the output layer, the same block also delivers the classification. It sits between the layer weight/bias memories and the `node` datapath.

---
 rtl/mlp_pkg.sv | 17 +
 rtl/argmax_tracker.sv | 40 ++++
 rtl/hidden_layer_sequencer.sv | 140 ++++++++++++++
 tb/tb_hidden_layer_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and default dimensions for the MLP layer datapath.
package mlp_pkg;

    localparam int unsigned BITS         = 16;
    localparam int unsigned FRAC_BITS    = 11;
    localparam int unsigned IN_SIZE      = 784;
    localparam int unsigned HIDDEN_NODES = 50;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StRelease,
        StDone
    } seq_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed argmax over a stream of (value, index) captures.
// The first capture after clear loads unconditionally; ties keep the earlier index.
module argmax_tracker #(
    parameter int unsigned bits  = 16,
    parameter int unsigned idx_w = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    valid,
    input  logic signed [bits-1:0]  value,
    input  logic        [idx_w-1:0] index,
    output logic signed [bits-1:0]  max_value,
    output logic        [idx_w-1:0] max_index
);

    logic have_max_q;
    logic take;

    assign take = valid && (!have_max_q || (value > max_value));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            have_max_q <= 1'b0;
            max_value  <= '0;
            max_index  <= '0;
        end else begin
            if (clear) begin
                have_max_q <= 1'b0;
            end else if (valid) begin
                have_max_q <= 1'b1;
            end
            if (take) begin
                max_value <= value;
                max_index <= index;
            end
        end
    end

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Steps one shared node datapath through every neuron of a layer via the start/ready
// handshake, buffering each result and tracking the layer argmax.
module hidden_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int unsigned bits            = BITS,
    parameter int unsigned fractional_bits = FRAC_BITS,
    parameter int unsigned in_size         = IN_SIZE,
    parameter int unsigned num_nodes       = HIDDEN_NODES,
    parameter int unsigned idx_w           = (num_nodes > 1) ? $clog2(num_nodes) : 1,
    parameter int unsigned addr_w          =
        (num_nodes * in_size > 1) ? $clog2(num_nodes * in_size) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     layer_start,
    output logic                     busy,
    output logic                     layer_done,
    output logic        [idx_w-1:0]  node_index,
    output logic        [addr_w-1:0] weight_base,
    output logic                     node_start,
    input  logic                     node_ready,
    input  logic signed [bits-1:0]   node_out,
    output logic                     result_wr_en,
    output logic        [idx_w-1:0]  result_addr,
    output logic signed [bits-1:0]   result_data,
    output logic signed [bits-1:0]   max_value,
    output logic        [idx_w-1:0]  max_index
);

    localparam logic [idx_w-1:0]  last_idx   = idx_w'(num_nodes - 1);
    localparam logic [addr_w-1:0] row_stride = addr_w'(in_size);

    if (fractional_bits >= bits) begin : g_frac_check
        $error("fractional_bits must be smaller than bits");
    end

    seq_state_t state_q, state_d;

    logic                    busy_d, layer_done_d, node_start_d, result_wr_en_d;
    logic        [idx_w-1:0] node_index_d, result_addr_d;
    logic       [addr_w-1:0] weight_base_d;
    logic signed  [bits-1:0] result_data_d;
    logic                    argmax_clear, capture;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (layer_start) state_d = StLoad;
            StLoad:    state_d = StRun;
            StRun:     if (node_ready) state_d = StRelease;
            StRelease: if (!node_ready) state_d = (node_index == last_idx) ? StDone : StLoad;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; everything leaves the block from a flop.
    always_comb begin
        node_index_d   = node_index;
        weight_base_d  = weight_base;
        result_addr_d  = result_addr;
        result_data_d  = result_data;
        result_wr_en_d = 1'b0;
        argmax_clear   = 1'b0;
        capture        = 1'b0;
        case (state_q)
            StIdle: begin
                if (layer_start) begin
                    node_index_d  = '0;
                    weight_base_d = '0;
                    argmax_clear  = 1'b1;
                end
            end
            StRun: begin
                if (node_ready) begin
                    capture        = 1'b1;
                    result_wr_en_d = 1'b1;
                    result_data_d  = node_out;
                    result_addr_d  = node_index;
                end
            end
            StRelease: begin
                if (!node_ready && (node_index != last_idx)) begin
                    node_index_d  = node_index + idx_w'(1);
                    weight_base_d = weight_base + row_stride;
                end
            end
            default: ;
        endcase
        busy_d       = state_d inside {StLoad, StRun, StRelease};
        node_start_d = (state_d == StRun);
        layer_done_d = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            layer_done   <= 1'b0;
            node_start   <= 1'b0;
            result_wr_en <= 1'b0;
            node_index   <= '0;
            weight_base  <= '0;
            result_addr  <= '0;
            result_data  <= '0;
        end else begin
            busy         <= busy_d;
            layer_done   <= layer_done_d;
            node_start   <= node_start_d;
            result_wr_en <= result_wr_en_d;
            node_index   <= node_index_d;
            weight_base  <= weight_base_d;
            result_addr  <= result_addr_d;
            result_data  <= result_data_d;
        end
    end

    argmax_tracker #(
        .bits  (bits),
        .idx_w (idx_w)
    ) u_argmax (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (argmax_clear),
        .valid     (capture),
        .value     (node_out),
        .index     (node_index),
        .max_value (max_value),
        .max_index (max_index)
    );

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Bench for hidden_layer_sequencer: node responder model, event scoreboard with a
// reference argmax, and directed scenarios with hand-computed expectations.
module tb_hidden_layer_sequencer;

    localparam int NN  = 4;
    localparam int INS = 784;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               layer_start = 1'b0;
    logic               busy, layer_done, node_start, result_wr_en;
    logic               node_ready;
    logic signed [15:0] node_out;
    logic        [1:0]  node_index, result_addr, max_index;
    logic        [11:0] weight_base;
    logic signed [15:0] result_data, max_value;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] reply_vals [NN];
    int          sticky = 0;
    int          exp_cyc = 0;
    wr_t         exp_q [$];
    int          writes = 0;
    int          total_done = 0;
    logic [15:0] wb_seen [NN];
    logic signed [15:0] mx;
    int          mx_idx;

    always #5 clock = ~clock;

    hidden_layer_sequencer #(
        .num_nodes (NN),
        .in_size   (INS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .layer_start  (layer_start),
        .busy         (busy),
        .layer_done   (layer_done),
        .node_index   (node_index),
        .weight_base  (weight_base),
        .node_start   (node_start),
        .node_ready   (node_ready),
        .node_out     (node_out),
        .result_wr_en (result_wr_en),
        .result_addr  (result_addr),
        .result_data  (result_data),
        .max_value    (max_value),
        .max_index    (max_index)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Node responder: ready 5 cycles into start, held `sticky` cycles after start drops.
    initial begin : node_model
        int cnt = 0;
        int hold = 0;
        int reply_k = 0;
        logic prev_busy = 1'b0;
        node_ready = 1'b0;
        node_out   = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                cnt = 0; hold = 0; prev_busy = 1'b0;
                node_ready = 1'b0;
                exp_q.delete();
            end else begin
                if (busy && !prev_busy) reply_k = 0;
                prev_busy = busy;
                if (!node_ready) begin
                    if (node_start) begin
                        cnt++;
                        if (cnt == 5) begin
                            node_out   = reply_vals[reply_k % NN];
                            node_ready = 1'b1;
                            exp_q.push_back('{addr: reply_k, data: reply_vals[reply_k % NN]});
                            reply_k++;
                            cnt = 0;
                        end
                    end else begin
                        cnt = 0;
                    end
                end else if (!node_start) begin
                    if (hold == sticky) begin
                        node_ready = 1'b0;
                        hold = 0;
                    end else begin
                        hold++;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the layer-level model.
    initial begin : compare
        logic prev_busy = 1'b0;
        logic prev_wr = 1'b0;
        logic prev_start = 1'b0;
        logic first = 1'b1;
        int   done_in_layer = 0;
        int   cyc = 0;
        wr_t  e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_busy = 1'b0; prev_wr = 1'b0; prev_start = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    writes = 0; first = 1'b1; done_in_layer = 0; cyc = 0;
                end else begin
                    cyc++;
                end
                if (node_start) begin
                    check("start_implies_busy", 16'(busy), 16'd1);
                    check("node_index", 16'(node_index), 16'(writes));
                    check("weight_base", 16'(weight_base), 16'(writes * INS));
                    if (writes < NN) wb_seen[writes] = 16'(weight_base);
                    if (!prev_start) check("start_rose_ready_low", 16'(node_ready), 16'd0);
                end
                if (result_wr_en) begin
                    check("wr_single_cycle", 16'(prev_wr), 16'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h, expected none",
                                 result_addr, result_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_addr", 16'(result_addr), 16'(e.addr));
                        check("result_data", result_data, e.data);
                        if (first || ($signed(e.data) > mx)) begin
                            mx = e.data;
                            mx_idx = e.addr;
                        end
                        first = 1'b0;
                        check("max_value", max_value, mx);
                        check("max_index", 16'(max_index), 16'(mx_idx));
                    end
                    writes++;
                end
                if (layer_done) begin
                    check("single_done", 16'(done_in_layer), 16'd0);
                    check("busy_low_at_done", 16'(busy), 16'd0);
                    check("writes_per_layer", 16'(writes), 16'(NN));
                    check("final_max_value", max_value, mx);
                    check("final_max_index", 16'(max_index), 16'(mx_idx));
                    if (exp_cyc != 0) check("layer_cycles", 16'(cyc), 16'(exp_cyc));
                    done_in_layer++;
                    total_done++;
                end
                prev_busy  = busy;
                prev_wr    = result_wr_en;
                prev_start = node_start;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #1 layer_start = 1'b1;
        @(posedge clock);
        #1 layer_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            got = layer_done;
        end
        check("layer_done_within_budget", 16'(got), 16'd1);
    endtask

    task automatic wait_run_index(input int idx, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            got = node_start && (node_index == 2'(idx));
        end
        check("reached_run_index", 16'(got), 16'd1);
    endtask

    task automatic set_vals(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        reply_vals[0] = a; reply_vals[1] = b; reply_vals[2] = c; reply_vals[3] = d;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int done_before;
        set_vals(16'h0800, 16'hF800, 16'h1000, 16'h0400);

        // Reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_layer_done", 16'(layer_done), 16'd0);
        check("rst_node_index", 16'(node_index), 16'd0);
        check("rst_weight_base", 16'(weight_base), 16'd0);
        check("rst_node_start", 16'(node_start), 16'd0);
        check("rst_wr_en", 16'(result_wr_en), 16'd0);
        check("rst_result_addr", 16'(result_addr), 16'd0);
        check("rst_result_data", result_data, 16'd0);
        check("rst_max_value", max_value, 16'd0);
        check("rst_max_index", 16'(max_index), 16'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Happy path: 7 cycles per neuron
        exp_cyc = 28;
        done_before = total_done;
        pulse_start();
        wait_done(200);
        check("happy_max_index", 16'(max_index), 16'd2);
        check("happy_max_value", max_value, 16'h1000);
        check("happy_wb0", wb_seen[0], 16'd0);
        check("happy_wb1", wb_seen[1], 16'd784);
        check("happy_wb2", wb_seen[2], 16'd1568);
        check("happy_wb3", wb_seen[3], 16'd2352);
        check("happy_done_count", 16'(total_done - done_before), 16'd1);

        // Ties and negatives
        set_vals(16'hFC00, 16'hFC00, 16'hF000, 16'hFC00);
        pulse_start();
        wait_done(200);
        check("tie_max_index", 16'(max_index), 16'd0);
        check("tie_max_value", max_value, 16'hFC00);

        // Sticky ready: RELEASE stretches to 5 cycles, 11 per neuron
        set_vals(16'h0800, 16'hF800, 16'h1000, 16'h0400);
        sticky = 4;
        exp_cyc = 44;
        pulse_start();
        wait_done(300);
        check("sticky_max_index", 16'(max_index), 16'd2);
        sticky = 0;
        exp_cyc = 28;

        // Mid-layer reset during neuron 2's RUN
        pulse_start();
        wait_run_index(2, 100);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_no_write", 16'(result_wr_en), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_index", 16'(node_index), 16'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        pulse_start();
        @(negedge clock);
        check("restart_busy", 16'(busy), 16'd1);
        check("restart_index", 16'(node_index), 16'd0);
        wait_done(200);
        check("restart_max_index", 16'(max_index), 16'd2);

        // Start while busy is ignored; start held across the done cycle begins a new layer
        pulse_start();
        wait_run_index(1, 100);
        layer_start = 1'b1;
        @(posedge clock);
        #1 layer_start = 1'b0;
        @(negedge clock);
        check("ignored_start_index", 16'(node_index), 16'd1);
        check("ignored_start_busy", 16'(busy), 16'd1);
        wait_done(200);
        layer_start = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 layer_start = 1'b0;
        @(negedge clock);
        check("chained_busy", 16'(busy), 16'd1);
        check("chained_index", 16'(node_index), 16'd0);
        wait_done(200);
        check("chained_max_value", max_value, 16'h1000);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
